// File: rtl/inspection_result_tally_pkg.sv
// Shared definitions for the inspection result path: verdict codes, indicator
// state encodings and the hex segment glyph table.
package inspection_result_tally_pkg;

  localparam logic [1:0] RES_IDLE = 2'b00;
  localparam logic [1:0] RES_ADV  = 2'b01;
  localparam logic [1:0] RES_REJ  = 2'b10;
  localparam logic [1:0] RES_APP  = 2'b11;

  typedef enum logic [1:0] {
    IND_IDLE     = 2'd0,
    IND_SHOW_APP = 2'd1,
    IND_SHOW_REJ = 2'd2
  } ind_state_e;

  // Entry-edge verdict events; app and rej can never both be set.
  typedef struct packed {
    logic app;
    logic rej;
  } verdict_ev_t;

  // Segment order {g,f,e,d,c,b,a}, active-high; entry n is the glyph for hex n.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/inspection_result_tally_hex_to_7seg.sv
// Combinational nibble-to-segment decoder; the caller registers the result.
module hex_to_7seg
  import inspection_result_tally_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_GLYPHS[nib_i];

endmodule

// File: rtl/inspection_result_tally.sv
// Tallies approve/reject verdicts from the result stage, stretches each verdict
// into a visible LED pulse and shows the selected count on a 7-segment digit.
module inspection_result_tally
  import inspection_result_tally_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int STRETCH_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       result_code,
  input  logic             clear,
  input  logic             show_sel,
  output logic [CNT_W-1:0] approve_cnt,
  output logic [CNT_W-1:0] reject_cnt,
  output logic             sat,
  output logic             led_approve,
  output logic             led_reject,
  output logic             led_busy,
  output logic [6:0]       seg
);

  localparam int               TMR_W    = $clog2(STRETCH_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       prev_code_q;
  verdict_ev_t      ev;
  logic [CNT_W-1:0] app_cnt_q, app_cnt_d;
  logic [CNT_W-1:0] rej_cnt_q, rej_cnt_d;
  logic             sat_q, sat_d;
  ind_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             busy_q;
  logic [6:0]       seg_q, seg_dec;
  logic [CNT_W-1:0] sel_cnt;

  // A held code counts once: only the cycle it is entered raises an event.
  assign ev.app = (result_code == RES_APP) && (prev_code_q != RES_APP);
  assign ev.rej = (result_code == RES_REJ) && (prev_code_q != RES_REJ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_code_q <= RES_IDLE;
      busy_q      <= 1'b0;
    end else begin
      prev_code_q <= result_code;
      busy_q      <= (result_code == RES_ADV);
    end
  end

  // Counters saturate; clear wins over a same-cycle event.
  always_comb begin
    app_cnt_d = app_cnt_q;
    rej_cnt_d = rej_cnt_q;
    sat_d     = sat_q;
    if (clear) begin
      app_cnt_d = '0;
      rej_cnt_d = '0;
      sat_d     = 1'b0;
    end else begin
      if (ev.app && (app_cnt_q != CNT_MAX)) app_cnt_d = app_cnt_q + CNT_W'(1);
      if (ev.rej && (rej_cnt_q != CNT_MAX)) rej_cnt_d = rej_cnt_q + CNT_W'(1);
      sat_d = sat_q | (app_cnt_d == CNT_MAX) | (rej_cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      app_cnt_q <= '0;
      rej_cnt_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      app_cnt_q <= app_cnt_d;
      rej_cnt_q <= rej_cnt_d;
      sat_q     <= sat_d;
    end
  end

  // Indicator FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IND_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Indicator FSM: next state. Any new verdict retriggers, even at timer==0.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (ev.app) begin
      state_d = IND_SHOW_APP;
      tmr_d   = TMR_LOAD;
    end else if (ev.rej) begin
      state_d = IND_SHOW_REJ;
      tmr_d   = TMR_LOAD;
    end else begin
      case (state_q)
        IND_SHOW_APP, IND_SHOW_REJ: begin
          if (tmr_q == '0) state_d = IND_IDLE;
          else             tmr_d   = tmr_q - TMR_W'(1);
        end
        default: state_d = IND_IDLE;
      endcase
    end
  end

  // Indicator FSM: outputs from registered state only.
  always_comb begin
    led_approve = (state_q == IND_SHOW_APP);
    led_reject  = (state_q == IND_SHOW_REJ);
  end

  assign sel_cnt = show_sel ? rej_cnt_q : app_cnt_q;

  hex_to_7seg u_hex (
    .nib_i (sel_cnt[3:0]),
    .seg_o (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_q <= '0;
    else        seg_q <= seg_dec;
  end

  assign approve_cnt = app_cnt_q;
  assign reject_cnt  = rej_cnt_q;
  assign sat         = sat_q;
  assign led_busy    = busy_q;
  assign seg         = seg_q;

endmodule

// File: tb/tb_inspection_result_tally.sv
// Directed bench: stimulus queues expected output values tagged with the cycle
// they must appear in; a negedge monitor pops and compares them.
module tb_inspection_result_tally;

  localparam int CNT_W = 4;
  localparam int STRETCH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       result_code;
  logic             clear;
  logic             show_sel;
  logic [CNT_W-1:0] approve_cnt, reject_cnt;
  logic             sat, led_approve, led_reject, led_busy;
  logic [6:0]       seg;

  inspection_result_tally #(.CNT_W(CNT_W), .STRETCH_CYCLES(STRETCH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .result_code (result_code),
    .clear       (clear),
    .show_sel    (show_sel),
    .approve_cnt (approve_cnt),
    .reject_cnt  (reject_cnt),
    .sat         (sat),
    .led_approve (led_approve),
    .led_reject  (led_reject),
    .led_busy    (led_busy),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  typedef enum int {F_APP, F_REJ, F_SAT, F_LA, F_LR, F_LB, F_SEG} fld_e;
  typedef struct {
    int   cyc;
    fld_e f;
    int   val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(fld_e f);
    case (f)
      F_APP:   return int'(approve_cnt);
      F_REJ:   return int'(reject_cnt);
      F_SAT:   return int'(sat);
      F_LA:    return int'(led_approve);
      F_LR:    return int'(led_reject);
      F_LB:    return int'(led_busy);
      default: return int'(seg);
    endcase
  endfunction

  function automatic string fname(fld_e f);
    case (f)
      F_APP:   return "approve_cnt";
      F_REJ:   return "reject_cnt";
      F_SAT:   return "sat";
      F_LA:    return "led_approve";
      F_LR:    return "led_reject";
      F_LB:    return "led_busy";
      default: return "seg";
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        int a;
        a = actual(q[i].f);
        checks++;
        if (a != q[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0h expected=%0h", fname(q[i].f), cyc, a, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(int dc, fld_e f, int val);
    exp_t e;
    e.cyc = cyc + dc;
    e.f   = f;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic expect_all_zero(int dc);
    expect_at(dc, F_APP, 0); expect_at(dc, F_REJ, 0); expect_at(dc, F_SAT, 0);
    expect_at(dc, F_LA, 0);  expect_at(dc, F_LR, 0);  expect_at(dc, F_LB, 0);
    expect_at(dc, F_SEG, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; result_code = 2'b00; clear = 1'b0; show_sel = 1'b0;
    tick(); tick();
    expect_all_zero(0);
    tick();
    rst_n = 1'b1;
    expect_at(1, F_SEG, 7'h3F);
    repeat (10) tick();
    expect_at(0, F_APP, 0); expect_at(0, F_REJ, 0); expect_at(0, F_SAT, 0);
    expect_at(0, F_LA, 0);  expect_at(0, F_LR, 0);  expect_at(0, F_SEG, 7'h3F);

    // single-cycle approve: count once, LED stretched STRETCH cycles
    expect_at(0, F_LA, 0);
    result_code = 2'b11;
    expect_at(1, F_APP, 1); expect_at(1, F_REJ, 0); expect_at(2, F_SEG, 7'h06);
    for (int k = 1; k <= STRETCH; k++) expect_at(k, F_LA, 1);
    expect_at(STRETCH + 1, F_LA, 0);
    tick(); result_code = 2'b00;
    repeat (10) tick();

    // reject held 5 cycles counts once, re-entry counts again
    result_code = 2'b10;
    expect_at(1, F_REJ, 1); expect_at(5, F_REJ, 1);
    repeat (5) tick();
    result_code = 2'b00; tick();
    result_code = 2'b10;
    expect_at(1, F_REJ, 2); expect_at(1, F_APP, 1);
    tick(); result_code = 2'b00;
    repeat (3) tick();
    expect_at(0, F_SEG, 7'h06);
    show_sel = 1'b1;
    expect_at(1, F_SEG, 7'h5B);
    tick();
    repeat (12) tick();

    // approve then reject 3 cycles later: LED handover, never both
    for (int k = 0; k <= 13; k++) begin
      expect_at(k, F_LA, (k >= 1 && k <= 3) ? 1 : 0);
      expect_at(k, F_LR, (k >= 4 && k <= 11) ? 1 : 0);
    end
    result_code = 2'b11; tick();
    result_code = 2'b00; tick(); tick();
    result_code = 2'b10; tick();
    result_code = 2'b00;
    expect_at(0, F_APP, 2); expect_at(1, F_SEG, 7'h4F);
    repeat (12) tick();

    // saturation at 15, then clear beats a coincident event
    show_sel = 1'b0;
    clear = 1'b1;
    expect_at(1, F_APP, 0); expect_at(1, F_REJ, 0); expect_at(1, F_SAT, 0);
    tick(); clear = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      result_code = 2'b11;
      expect_at(1, F_APP, (k > 15) ? 15 : k);
      expect_at(1, F_SAT, (k >= 15) ? 1 : 0);
      if (k == 15) expect_at(2, F_SEG, 7'h71);
      tick(); result_code = 2'b00; tick();
    end
    result_code = 2'b11; clear = 1'b1;
    expect_at(1, F_APP, 0); expect_at(1, F_SAT, 0); expect_at(1, F_LA, 1);
    tick(); result_code = 2'b00; clear = 1'b0;
    expect_at(1, F_APP, 0); expect_at(1, F_SAT, 0);
    tick();
    repeat (10) tick();

    // async reset mid-stretch with count 5, then busy after release
    for (int k = 1; k <= 5; k++) begin
      result_code = 2'b11; tick(); result_code = 2'b00; tick();
    end
    expect_at(0, F_APP, 5); expect_at(0, F_LA, 1);
    tick();
    rst_n = 1'b0;
    expect_all_zero(0);
    tick(); tick();
    rst_n = 1'b1; result_code = 2'b01;
    expect_at(0, F_LB, 0);
    expect_at(1, F_LB, 1); expect_at(1, F_APP, 0); expect_at(1, F_SEG, 7'h3F);
    tick(); result_code = 2'b00;
    expect_at(1, F_LB, 0); expect_at(1, F_APP, 0);
    repeat (4) tick();

    for (int w = 0; w < 20 && q.size() != 0; w++) tick();
    if (q.size() != 0) begin
      $display("FAIL pending_expectations left=%0d expected=0", q.size());
      errors += q.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
